// File: rtl/keycode_pio_pkg.sv
// Shared address-map helpers and STAT bit positions for the keycode PIO/FIFO slice.
package keycode_pio_pkg;

    localparam int unsigned ST_FULL    = 0;
    localparam int unsigned ST_EMPTY   = 1;
    localparam int unsigned ST_OVF     = 2;
    localparam int unsigned ST_IRQEN   = 3;
    localparam int unsigned ST_LVL_LSB = 8;

    // The event and status words occupy the top two word addresses.
    function automatic int unsigned EVT_ADDR(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd2;
    endfunction

    function automatic int unsigned STAT_ADDR(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

endpackage

// File: rtl/keycode_evt_fifo.sv
// Synchronous event FIFO: register array, wrapping pointers, explicit level count.
module keycode_evt_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         push_data_i,
    input  logic                      pop_i,
    output logic [DATA_W-1:0]         rd_data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A pop frees the slot this cycle, so a push at full is still accepted.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/keycode_pio_fifo.sv
// Avalon-MM keycode PIO: NUM_CH held-key registers, event FIFO, STAT/control.
// Optional interrupt output enabled by defining KEYCODE_PIO_FIFO_IRQ_EN.
module keycode_pio_fifo
    import keycode_pio_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    output logic [NUM_CH*DATA_W-1:0] out_keys,
    output logic [DATA_W-1:0]        evt_data,
    output logic                     evt_valid,
    input  logic                     evt_ready
`ifdef KEYCODE_PIO_FIFO_IRQ_EN
    ,
    output logic                     irq
`endif
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] EVT_A  = ADDR_W'(EVT_ADDR(ADDR_W));
    localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(STAT_ADDR(ADDR_W));

    if (NUM_CH + 2 > 2**ADDR_W) begin : g_addr_check
        $error("keycode_pio_fifo: NUM_CH+2 exceeds 2**ADDR_W word addresses");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("keycode_pio_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [DATA_W-1:0] key_q [NUM_CH];
    logic              overflow_q, overflow_d;
    logic              irq_en;
    logic              wr_en, push, pop, ovf_clr;
    logic              fifo_full, fifo_empty, fifo_drop;
    logic [LW-1:0]     fifo_level;
    logic              unused_wdata;

    assign unused_wdata = ^writedata;
    assign wr_en   = chipselect && !write_n;
    assign push    = wr_en && (address == EVT_A);
    assign pop     = evt_valid && evt_ready;
    assign ovf_clr = wr_en && (address == STAT_A) && writedata[ST_OVF];

    keycode_evt_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (writedata[DATA_W-1:0]),
        .pop_i       (pop),
        .rd_data_o   (evt_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level),
        .drop_o      (fifo_drop)
    );

    assign evt_valid = !fifo_empty;

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                key_q[i] <= '0;
            end else if (wr_en && address == ADDR_W'(i)) begin
                key_q[i] <= writedata[DATA_W-1:0];
            end
        end
    end

    always_comb begin
        out_keys = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            out_keys[i*DATA_W +: DATA_W] = key_q[i];
        end
    end

    // A fresh overflow outranks a simultaneous write-1-to-clear.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr)   overflow_d = 1'b0;
        if (fifo_drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

`ifdef KEYCODE_PIO_FIFO_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_en && address == STAT_A) irq_en_q <= writedata[ST_IRQEN];
            irq_q <= irq_en_q && (fifo_empty || overflow_q);
        end
    end

    assign irq_en = irq_en_q;
    assign irq    = irq_q;
`else
    assign irq_en = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (address == ADDR_W'(i)) readdata[DATA_W-1:0] = key_q[i];
        end
        if (address == EVT_A) begin
            readdata[LW-1:0] = fifo_level;
        end
        if (address == STAT_A) begin
            readdata[ST_FULL]              = fifo_full;
            readdata[ST_EMPTY]             = fifo_empty;
            readdata[ST_OVF]               = overflow_q;
            readdata[ST_IRQEN]             = irq_en;
            readdata[ST_LVL_LSB +: LW]     = fifo_level;
        end
    end

endmodule

// File: doc/keycode_pio_fifo.md
Name: keycode_pio_fifo

Overview:
- Parametrised successor to the single-byte keycode PIO, sitting on the Avalon-MM bus between the NIOS keyboard driver and the game logic.
- Provides NUM_CH held-keycode registers, driven as a packed level output, for multi-key rollover.
- Adds an event FIFO: software pushes key-press events, and game logic pops them over a valid/ready stream.
- Adds a status/control register with sticky overflow.

Parameters:
- DATA_W, 8, keycode width in bits (1..16)
- NUM_CH, 4, number of held-keycode registers (1..6)
- FIFO_DEPTH, 8, event FIFO entries (power of two, 2..64)
- ADDR_W, 3, Avalon word-address width; elaboration error if NUM_CH+2 > 2**ADDR_W

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  ADDR_W  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data
- out_keys  out  NUM_CH*DATA_W  packed held keycodes; channel i at bits [i*DATA_W +: DATA_W]
- evt_data  out  DATA_W  head-of-FIFO keycode
- evt_valid  out  1  FIFO not empty
- evt_ready  in  1  consumer accepts head

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset, sampled on the clk rising edge.
- Address map:
  - 0..NUM_CH-1: KEY[i], read/write, DATA_W bits.
  - EVT_ADDR = 2**ADDR_W-2: a write pushes writedata[DATA_W-1:0]. A read returns the FIFO level.
  - STAT_ADDR = 2**ADDR_W-1: bit0 full, bit1 empty, bit2 overflow (sticky, write 1 to clear), bit3 irq_en (R/W, present only with the optional feature). Bits [15:8] hold the level.
  - Unmapped addresses read 0; writes to them are ignored.
- Write strobe: a write occurs when chipselect && !write_n, and takes effect at the next clk edge.
- Reads: zero wait states. readdata is combinational from address and registered state. Unused upper bits are zero.
- Reset: all KEY registers 0, so out_keys=0. FIFO empty, so evt_valid=0 and level=0. overflow=0, irq_en=0. evt_data is don't-care while evt_valid=0; implement it as mem[rd_ptr].
- Reset mid-operation: reset has priority over any concurrent write or pop in the same cycle. FIFO contents are discarded.
- FIFO structure: register array, rd_ptr/wr_ptr of log2(FIFO_DEPTH) bits with natural wrap, plus a count of log2(FIFO_DEPTH)+1 bits.
  - pop = evt_valid && evt_ready.
  - push = CPU write to EVT_ADDR.
- Push into a non-full FIFO: the entry is stored and the level increments the following cycle.
- Push when full without a pop: the data is dropped, overflow is set, and the level is unchanged.
- Push when full with a pop in the same cycle: the push is accepted, and the level stays at FIFO_DEPTH.
- Push when empty: evt_valid rises the cycle after the push. There is no fall-through.
- Push and pop in the same cycle: the level is unchanged.
- evt_data must hold steady while evt_valid && !evt_ready.
- Overflow clear vs set: if a write-1-to-clear on overflow coincides with a new overflow event, the set wins.
- KEY registers: writes affect only the addressed channel. out_keys is a direct register output, with one cycle from write to output.

Optional Feature:
- Macro: KEYCODE_PIO_FIFO_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit), registered.
  - irq = irq_en && (evt_valid==0 || overflow) is registered, so it appears one cycle after the condition. This lets the CPU refill on drain or see overflow.
  - STAT bit3 is writable.
- When undefined:
  - No irq port.
  - STAT bit3 reads 0, and writes to it are ignored.

Decomposition:
- Package keycode_pio_pkg holds:
  - localparam functions EVT_ADDR(ADDR_W) and STAT_ADDR(ADDR_W);
  - STAT bit indices (ST_FULL=0, ST_EMPTY=1, ST_OVF=2, ST_IRQEN=3, ST_LVL_LSB=8).
- One sub-module, keycode_evt_fifo, is a synchronous FIFO with push/pop/full/empty/level and DATA_W/DEPTH parameters. The top level holds the Avalon decode, KEY registers, STAT and irq.

Test Plan:
- Reset state: hold reset 2 cycles with writes active, then release. Required: out_keys=0, evt_valid=0, STAT reads 0x0002, all KEY reads return 0.
- KEY channel isolation: write KEY2=0x1A, then KEY0=0x04. Required: out_keys=0x001A0004 at NUM_CH=4, DATA_W=8; KEY1 and KEY3 read 0.
- FIFO order and handshake: push 0x04, 0x05, 0x06 with evt_ready=0. Required: level=3, evt_data=0x04 held. Then evt_ready=1 for 3 cycles. Required: 0x04, 0x05, 0x06 emitted in order, then evt_valid=0.
- Overflow: push 9 entries into DEPTH=8. Required: STAT full=1, overflow=1, level=8, the 9th value never appears. Write 0x4 to STAT. Required: overflow=0.
- Full boundary: at full, push plus pop in the same cycle. Required: push accepted, overflow stays 0, level=8. Then drain all and check wrap-around ordering across 16 total entries.
- With KEYCODE_PIO_FIFO_IRQ_EN: set irq_en, empty FIFO. Required: irq=1 one cycle later. Push one entry. Required: irq=0 the cycle after evt_valid rises.
